// File: rtl/run_statistics_counter.sv
// Counts run cycles and F0 fetches from a start pulse until halt, with a req/ack read port.
// Define CYCLE_LIMIT_EN to add a watchdog that ends a run after CYCLE_LIMIT cycles.
module run_statistics_counter #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned CYCLE_LIMIT = 1000000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        halt_i,
  input  logic        dbg_f0_i,
  input  logic        rd_req_i,
  input  logic [1:0]  rd_sel_i,
  output logic        rd_ack_o,
  output logic [31:0] rd_data_o,
  output logic        running_o,
  output logic        done_o,
  output logic        overflow_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0]      ID_WORD = 32'hCDEC_5747;

  state_e           state_q;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] ins_cnt_q, ins_cnt_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q;
  logic             running_q, done_q;
  logic             rd_ack_q;
  logic [31:0]      rd_data_q, rd_data_d;

`ifdef CYCLE_LIMIT_EN
  logic limit_hit;
  assign limit_hit = (32'(cyc_cnt_q) == CYCLE_LIMIT);
`endif

  // Saturating increments for a normal counting cycle in RUN.
  always_comb begin
    cyc_cnt_d  = cyc_cnt_q;
    ins_cnt_d  = ins_cnt_q;
    overflow_d = overflow_q;
    if (cyc_cnt_q == CNT_MAX) begin
      overflow_d = 1'b1;
    end else begin
      cyc_cnt_d = cyc_cnt_q + 1'b1;
    end
    if (dbg_f0_i) begin
      if (ins_cnt_q == CNT_MAX) begin
        overflow_d = 1'b1;
      end else begin
        ins_cnt_d = ins_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cyc_cnt_q  <= '0;
      ins_cnt_q  <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else if (start_i) begin
      // start wins over halt and restarts from any state
      state_q    <= S_RUN;
      cyc_cnt_q  <= '0;
      ins_cnt_q  <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      running_q  <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
`ifdef CYCLE_LIMIT_EN
          if (limit_hit) begin
            state_q   <= S_HALTED;
            running_q <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else
`endif
          if (halt_i) begin
            state_q   <= S_HALTED;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            cyc_cnt_q  <= cyc_cnt_d;
            ins_cnt_q  <= ins_cnt_d;
            overflow_q <= overflow_d;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    case (rd_sel_i)
      2'd0:    rd_data_d = 32'(cyc_cnt_q);
      2'd1:    rd_data_d = 32'(ins_cnt_q);
      2'd2:    rd_data_d = {28'd0, timeout_q, overflow_q, done_q, running_q};
      default: rd_data_d = ID_WORD;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else if (rd_req_i && !rd_ack_q) begin
      rd_ack_q  <= 1'b1;
      rd_data_q <= rd_data_d;
    end else if (!rd_req_i) begin
      rd_ack_q  <= 1'b0;
    end
  end

  assign rd_ack_o   = rd_ack_q;
  assign rd_data_o  = rd_data_q;
  assign running_o  = running_q;
  assign done_o     = done_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_run_statistics_counter.sv
// Bench for run_statistics_counter: directed scenarios plus random traffic against a model.
module tb_run_statistics_counter;

  localparam int CNT_W = 4;
  localparam int LIMIT = 8;
  localparam int MAXV  = (1 << CNT_W) - 1;
`ifdef CYCLE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic        clock  = 1'b0;
  logic        reset  = 1'b1;
  logic        start  = 1'b0;
  logic        halt   = 1'b0;
  logic        dbg_f0 = 1'b0;
  logic        rd_req = 1'b0;
  logic [1:0]  rd_sel = 2'd0;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        running, done, overflow;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  run_statistics_counter #(.CNT_W(CNT_W), .CYCLE_LIMIT(LIMIT)) u_dut (
    .clock_i   (clock),
    .reset_i   (reset),
    .start_i   (start),
    .halt_i    (halt),
    .dbg_f0_i  (dbg_f0),
    .rd_req_i  (rd_req),
    .rd_sel_i  (rd_sel),
    .rd_ack_o  (rd_ack),
    .rd_data_o (rd_data),
    .running_o (running),
    .done_o    (done),
    .overflow_o(overflow)
  );

  // Reference model: mode 0 idle, 1 run, 2 halted.
  int          m_mode = 0;
  int          m_cyc  = 0;
  int          m_ins  = 0;
  bit          m_ovf  = 1'b0;
  bit          m_tmo  = 1'b0;
  bit          m_ack  = 1'b0;
  logic [31:0] m_data = 32'd0;

  function automatic logic [31:0] m_read(input logic [1:0] s);
    case (s)
      2'd0:    return m_cyc;
      2'd1:    return m_ins;
      2'd2:    return {28'd0, m_tmo, m_ovf, (m_mode == 2), (m_mode == 1)};
      default: return 32'hCDEC5747;
    endcase
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_ack = 1'b0; m_data = 32'd0;
    end else if (rd_req && !m_ack) begin
      m_data = m_read(rd_sel); m_ack = 1'b1;
    end else if (!rd_req) begin
      m_ack = 1'b0;
    end
    if (reset) begin
      m_mode = 0; m_cyc = 0; m_ins = 0; m_ovf = 0; m_tmo = 0; chk_en = 1'b1;
    end else if (start) begin
      m_mode = 1; m_cyc = 0; m_ins = 0; m_ovf = 0; m_tmo = 0;
    end else if (m_mode == 1) begin
      if (LIMIT_EN && m_cyc == LIMIT) begin
        m_mode = 2; m_tmo = 1'b1;
      end else if (halt) begin
        m_mode = 2;
      end else begin
        if (m_cyc == MAXV) m_ovf = 1'b1; else m_cyc++;
        if (dbg_f0) begin
          if (m_ins == MAXV) m_ovf = 1'b1; else m_ins++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_running",  running,  (m_mode == 1));
      check("model_done",     done,     (m_mode == 2));
      check("model_overflow", overflow, m_ovf);
      check("model_rd_ack",   rd_ack,   m_ack);
      check("model_rd_data",  rd_data,  m_data);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] s, output logic [31:0] d);
    int w;
    rd_sel = s; rd_req = 1'b1; w = 0;
    do begin tick(); w++; end while (!rd_ack && w < 8);
    if (!rd_ack) begin
      n_chk++; n_fail++;
      $display("FAIL read_ack_timeout: rd_ack stayed 0, expected 1");
    end
    d = rd_data; rd_req = 1'b0; w = 0;
    do begin tick(); w++; end while (rd_ack && w < 8);
    if (rd_ack) begin
      n_chk++; n_fail++;
      $display("FAIL read_ack_release: rd_ack stayed 1, expected 0");
    end
  endtask

  logic [31:0] d;
  logic [31:0] held;

  initial begin
    // Reset values
    tick(); tick(); reset = 1'b0;
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rd_ack", rd_ack, 0);
    check("rst_rd_data", rd_data, 0);

    // Ten run cycles, F0 on three of them, then halt (F0 high in the halt cycle is ignored)
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      dbg_f0 = (i == 2 || i == 5 || i == 7);
      tick();
    end
    dbg_f0 = 1'b1; halt = 1'b1; tick(); halt = 1'b0; dbg_f0 = 1'b0;
    check("t1_done", done, 1);
    do_read(2'd0, d); check("t1_cycles", d, LIMIT_EN ? 32'd8 : 32'd10);
    do_read(2'd1, d); check("t1_instrs", d, 32'd3);
    do_read(2'd2, d); check("t1_status", d, LIMIT_EN ? 32'b1010 : 32'b0010);

    // Saturation with CNT_W=4, then restart clears it
    pulse_start();
    repeat (20) tick();
    do_read(2'd0, d); check("t2_sat_cycles", d, LIMIT_EN ? 32'd8 : 32'd15);
    check("t2_overflow", overflow, LIMIT_EN ? 0 : 1);
    pulse_start();
    check("t2_ovf_clear", overflow, 0);
    check("t2_running", running, 1);
    halt = 1'b1; tick(); halt = 1'b0;
    do_read(2'd0, d); check("t2_cleared", d, 0);

    // start and halt together in RUN: start wins
    pulse_start();
    repeat (3) tick();
    start = 1'b1; halt = 1'b1; tick(); start = 1'b0;
    check("t3_still_run", running, 1);
    check("t3_not_done", done, 0);
    tick(); halt = 1'b0;
    check("t3_halted", done, 1);
    do_read(2'd0, d); check("t3_cycles", d, 0);

    // Held read during RUN: data frozen, rd_sel ignored after capture
    pulse_start();
    tick(); tick();
    rd_sel = 2'd0; rd_req = 1'b1; tick();
    check("t4_ack", rd_ack, 1);
    check("t4_capture", rd_data, 32'd2);
    held = rd_data;
    rd_sel = 2'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_hold_ack", rd_ack, 1);
      check("t4_hold_data", rd_data, held);
    end
    rd_req = 1'b0; tick();
    check("t4_ack_drop", rd_ack, 0);
    check("t4_data_keep", rd_data, held);
    do_read(2'd3, d); check("t4_id", d, 32'hCDEC5747);

    // Watchdog / no watchdog
    pulse_start();
    repeat (20) tick();
    if (LIMIT_EN) begin
      check("t5_wd_done", done, 1);
      do_read(2'd0, d); check("t5_wd_cycles", d, 32'd8);
      do_read(2'd2, d); check("t5_wd_timeout", d[3], 1);
    end else begin
      check("t5_still_run", running, 1);
      do_read(2'd2, d); check("t5_no_timeout", d[3], 0);
    end

    // Reset in the middle of a run and a read
    pulse_start();
    repeat (3) tick();
    dbg_f0 = 1'b1; rd_sel = 2'd0; rd_req = 1'b1; tick();
    check("t6_pre_ack", rd_ack, 1);
    reset = 1'b1; tick(); reset = 1'b0; rd_req = 1'b0; dbg_f0 = 1'b0;
    check("t6_running", running, 0);
    check("t6_done", done, 0);
    check("t6_ack", rd_ack, 0);
    check("t6_data", rd_data, 0);
    do_read(2'd0, d); check("t6_cycles", d, 0);
    do_read(2'd1, d); check("t6_instrs", d, 0);

    // Random traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      start  = ($urandom_range(0, 39) == 0);
      halt   = ($urandom_range(0, 29) == 0);
      dbg_f0 = $urandom_range(0, 1) == 1;
      rd_req = ($urandom_range(0, 3) != 0);
      rd_sel = 2'($urandom_range(0, 3));
      reset  = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0; start = 1'b0; halt = 1'b0; rd_req = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
